regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the single-write, dual-read processor register file.
- Adds configurable width, depth and read-port count, a second write port, and byte-enabled writes.
- Adds optional write-to-read bypass, optional hardwired-zero register 0, and a per-register busy scoreboard.
- Sits in the core datapath between decode (read and reserve) and writeback (write, busy clear).

Parameters:
WIDTH, 32, data bits per register; must be a multiple of 8
DEPTH, 32, number of registers; power of two, at least 2
NREAD, 2, number of combinational read ports, 1 to 4
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reserves
BYPASS, 1, 1 = reads return data being written in the current cycle

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all registers and busy bits
we_a  input  1  write enable, port A
wa_a  input  AW=$clog2(DEPTH)  write address, port A
wd_a  input  WIDTH  write data, port A
be_a  input  WIDTH/8  byte enables, port A
we_b  input  1  write enable, port B
wa_b  input  AW  write address, port B
wd_b  input  WIDTH  write data, port B
be_b  input  WIDTH/8  byte enables, port B
rsv_en  input  1  reserve request; sets the busy bit of rsv_addr
rsv_addr  input  AW  register to reserve
ra  input  NREAD*AW  packed read addresses; port i is bits [i*AW +: AW]
rd  output  NREAD*WIDTH  packed read data; port i is bits [i*WIDTH +: WIDTH]
busy  output  NREAD  busy bit of register ra[i]

Behaviour:
- Reset (async, active-high): all DEPTH registers are 0 and all busy bits are 0 immediately, independent of clk. While reset is high, rd is all zero and busy is all zero. Writes and reserves are ignored while reset is high.
- Write:
  - A port writes on the rising edge when we_x=1.
  - Only bytes with be_x[k]=1 are updated; other bytes hold.
  - we_x=1 with be_x=0 is a no-op for data but still clears busy (see Scoreboard).
- Collision (we_a=we_b=1, wa_a==wa_b): merged per byte. A byte with be_b set takes wd_b; otherwise a byte with be_a set takes wd_a; otherwise it holds. Port B has priority.
- Read: combinational, zero latency, all NREAD ports independent. Any address in 0..DEPTH-1 is legal; no out-of-range case exists.
- Bypass:
  - BYPASS=1: rd[i] equals the post-edge merged value whenever ra[i] matches an enabled write address this cycle, with the same byte and priority merge as above.
  - BYPASS=0: rd[i] shows the stored value; new data is visible the cycle after the edge.
- ZERO_REG=1: register 0 always reads 0, including through bypass. Writes to address 0 are discarded. rsv_en to address 0 is ignored and its busy bit is constant 0.
- Scoreboard:
  - rsv_en=1 sets busy[rsv_addr] at the edge.
  - Any enabled write (A or B) to address n clears busy[n] at the edge.
  - Same edge, reserve and write to the same address: the reserve wins and busy stays or becomes 1 (new producer). The write data is still committed.
  - busy[i] output = stored busy bit of ra[i]. There is no bypass on busy.
- Reset mid-operation: asserting reset between edges clears all state at once. The first edge after reset deasserts behaves as a normal cycle.
- No internal FSM beyond storage plus DEPTH busy flops. Implementation uses generate loops for the read ports.

Test Plan:
- Reset then write: pulse reset; next cycle we_a=1, wa_a=5, wd_a=A5A5A5A5, be_a=F -> after edge rd[0] (ra[0]=5) = A5A5A5A5. With BYPASS=1, rd[0] = A5A5A5A5 already in the write cycle.
- Byte enables: reg 10 = 5A5A5A5A; we_b=1, wa_b=10, wd_b=11223344, be_b=0101 -> reg 10 = 5A225A44.
- Collision: we_a, we_b both to reg 3; wd_a=AAAAAAAA, be_a=F; wd_b=BBBBBBBB, be_b=0011 -> reg 3 = AAAABBBB.
- Zero register: we_a=1, wa_a=0, wd_a=FFFFFFFF, plus rsv_en to 0 -> rd=0 and busy=0 for ra=0, both same cycle and next cycle.
- Scoreboard: rsv_en on reg 7 -> busy=1 next cycle. Write to reg 7 with rsv_en on reg 7 in the same cycle -> busy stays 1 and data is updated. Write only to reg 7 -> busy=0.
- Async reset mid-run: regs 5 and 10 nonzero and busy set; raise reset between clock edges -> rd=0 and busy=0 before the next edge. All registers read 0 after deassert.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port byte-enabled register file with write bypass, optional zero register and busy scoreboard
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we_a,
  input  logic [AW-1:0]          wa_a,
  input  logic [WIDTH-1:0]       wd_a,
  input  logic [WIDTH/8-1:0]     be_a,
  input  logic                   we_b,
  input  logic [AW-1:0]          wa_b,
  input  logic [WIDTH/8-1:0]     be_b,
  input  logic [WIDTH-1:0]       wd_b,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       busy
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      for (int k = 0; k < WIDTH/8; k++)
        mem_d[n][k*8 +: 8] = (we_b && wa_b == AW'(n) && be_b[k]) ? wd_b[k*8 +: 8] :
                             (we_a && wa_a == AW'(n) && be_a[k]) ? wd_a[k*8 +: 8] : mem_q[n][k*8 +: 8];
      busy_d[n] = (rsv_en && rsv_addr == AW'(n)) ? 1'b1 :
                  ((we_a && wa_a == AW'(n)) || (we_b && wa_b == AW'(n))) ? 1'b0 : busy_q[n];
      if (ZERO_REG != 0 && n == 0) begin
        mem_d[n] = '0;
        busy_d[n] = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < DEPTH; n++) mem_q[n] <= '0;
      busy_q <= '0;
    end else begin
      mem_q <= mem_d;
      busy_q <= busy_d;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = ra[i*AW +: AW];
    assign rd[i*WIDTH +: WIDTH] = reset ? '0 : (BYPASS != 0) ? mem_d[addr] : mem_q[addr];
    assign busy[i] = reset ? 1'b0 : busy_q[addr];
  end
endmodule
